// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bundle for param_sync_fifo: write/read requests, read data, status and error flags.
// Must be parameterised with the same DATA_WIDTH and DEPTH as the FIFO it connects to.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 10
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  i_wren;
  logic [DATA_WIDTH-1:0] i_wrdata;
  logic                  i_rden;
  logic                  i_clr_err;
  logic [DATA_WIDTH-1:0] o_rddata;
  logic                  o_valid;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_alm_full;
  logic                  o_alm_empty;
  logic [CW-1:0]         o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport slave (
    input  i_wren, i_wrdata, i_rden, i_clr_err,
    output o_rddata, o_valid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );

  modport master (
    output i_wren, i_wrdata, i_rden, i_clr_err,
    input  o_rddata, o_valid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO of DEPTH entries (any depth >= 2); read latency 1 cycle (FWFT=0) or 0 (FWFT=1).
// Full/empty reject writes/reads with sticky error flags; at full a same-cycle read frees the slot for the write.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 10,
  parameter int UPP_TH     = 4,
  parameter int LOW_TH     = 2,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               rstn,
  param_sync_fifo_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  overflow;
  logic                  underflow;

  assign rd_ok = bus.i_rden && (count != '0);
  assign wr_ok = bus.i_wren && ((count != CW'(DEPTH)) || rd_ok);

  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Explicit wrap compare so non-power-of-two depths never index past DEPTH-1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (wr_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wr_ok) mem[wr_ptr] <= bus.i_wrdata;
  end

  // An error event in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.i_wren && !wr_ok)  overflow <= 1'b1;
      else if (bus.i_clr_err)    overflow <= 1'b0;
      if (bus.i_rden && !rd_ok)  underflow <= 1'b1;
      else if (bus.i_clr_err)    underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.o_rddata = (count != '0) ? mem[rd_ptr] : '0;
      assign bus.o_valid  = (count != '0);
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rddata;
      logic                  valid;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          rddata <= '0;
          valid  <= 1'b0;
        end else begin
          valid <= rd_ok;
          if (rd_ok) rddata <= mem[rd_ptr];
        end
      end

      assign bus.o_rddata = rddata;
      assign bus.o_valid  = valid;
    end
  endgenerate

  assign bus.o_count     = count;
  assign bus.o_full      = (count == CW'(DEPTH));
  assign bus.o_empty     = (count == '0);
  assign bus.o_alm_full  = (count >= CW'(DEPTH - UPP_TH));
  assign bus.o_alm_empty = (count <= CW'(LOW_TH));
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: one standard-read instance and one FWFT instance, DEPTH=10.
module tb_param_sync_fifo;
  localparam int DW = 16;
  localparam int DP = 10;

  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) b0 ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) b1 ();

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .UPP_TH(4), .LOW_TH(2), .FWFT(0))
    u0 (.clk(clk), .rstn(rstn), .bus(b0));
  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .UPP_TH(4), .LOW_TH(2), .FWFT(1))
    u1 (.clk(clk), .rstn(rstn), .bus(b1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;

  initial begin
    int wcnt, rcnt, cyc;
    bit wr, rd;

    rstn = 1'b0;
    b0.i_wren = 0; b0.i_wrdata = '0; b0.i_rden = 0; b0.i_clr_err = 0;
    b1.i_wren = 0; b1.i_wrdata = '0; b1.i_rden = 0; b1.i_clr_err = 0;
    step();
    step();

    check("rst_empty",     b0.o_empty, 1);
    check("rst_alm_empty", b0.o_alm_empty, 1);
    check("rst_count",     b0.o_count, 0);
    check("rst_full",      b0.o_full, 0);
    check("rst_alm_full",  b0.o_alm_full, 0);
    check("rst_valid",     b0.o_valid, 0);
    check("rst_rddata",    b0.o_rddata, 0);
    check("rst_overflow",  b0.o_overflow, 0);
    check("rst_underflow", b0.o_underflow, 0);
    check("rst_fwft_valid", b1.o_valid, 0);
    rstn = 1'b1;
    step();

    // Fill 0x1..0xA
    for (int i = 1; i <= 10; i++) begin
      b0.i_wren = 1; b0.i_wrdata = DW'(i);
      step();
      check("fill_count", b0.o_count, i);
      if (i == 5) check("alm_full_at5", b0.o_alm_full, 0);
      if (i == 6) check("alm_full_at6", b0.o_alm_full, 1);
      if (i == 9) check("full_at9", b0.o_full, 0);
    end
    check("full_at10", b0.o_full, 1);
    check("overflow_before", b0.o_overflow, 0);
    b0.i_wrdata = 16'h000B;
    step();
    b0.i_wren = 0;
    check("overflow_set", b0.o_overflow, 1);
    check("overflow_count", b0.o_count, 10);

    // Drain
    for (int i = 1; i <= 10; i++) begin
      b0.i_rden = 1;
      step();
      check("drain_valid", b0.o_valid, 1);
      check("drain_data", b0.o_rddata, i);
      check("drain_count", b0.o_count, 10 - i);
      check("drain_alm_empty", b0.o_alm_empty, ((10 - i) <= 2) ? 1 : 0);
    end
    b0.i_rden = 0;
    step();
    check("idle_valid", b0.o_valid, 0);
    check("idle_hold", b0.o_rddata, 16'h000A);
    check("drained_empty", b0.o_empty, 1);
    check("no_underflow", b0.o_underflow, 0);

    b0.i_clr_err = 1;
    step();
    b0.i_clr_err = 0;
    check("clr_overflow", b0.o_overflow, 0);
    check("clr_underflow", b0.o_underflow, 0);

    // Interleaved traffic across the 9->0 wrap
    wcnt = 0; rcnt = 0; cyc = 0;
    while (rcnt < 25 && cyc < 400) begin
      rd = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      wr = (wcnt < 25) && ($urandom_range(0, 3) != 0) && (q.size() < DP || rd);
      b0.i_rden = rd; b0.i_wren = wr; b0.i_wrdata = DW'(16'h0100 + wcnt);
      step();
      if (rd) begin
        exp_d = q.pop_front();
        rcnt++;
        check("wrap_valid", b0.o_valid, 1);
        check("wrap_data", b0.o_rddata, exp_d);
      end else begin
        check("wrap_novalid", b0.o_valid, 0);
      end
      if (wr) begin
        q.push_back(DW'(16'h0100 + wcnt));
        wcnt++;
      end
      check("wrap_count", b0.o_count, q.size());
      cyc++;
    end
    b0.i_rden = 0; b0.i_wren = 0;
    check("wrap_done", rcnt, 25);
    check("wrap_no_err", {b0.o_overflow, b0.o_underflow}, 0);

    // Simultaneous access at full
    for (int i = 0; i < 10; i++) begin
      b0.i_wren = 1; b0.i_wrdata = DW'(16'h0201 + i);
      step();
    end
    check("sim_full", b0.o_full, 1);
    for (int k = 0; k < 3; k++) begin
      b0.i_wren = 1; b0.i_rden = 1; b0.i_wrdata = DW'(16'h020B + k);
      step();
      check("sim_count", b0.o_count, 10);
      check("sim_data", b0.o_rddata, 16'h0201 + k);
      check("sim_overflow", b0.o_overflow, 0);
    end
    b0.i_wren = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("sim_drain", b0.o_rddata, 16'h0204 + i);
    end
    b0.i_rden = 0;
    step();
    check("sim_drained", b0.o_empty, 1);

    // Simultaneous access at empty
    b0.i_wren = 1; b0.i_rden = 1; b0.i_wrdata = 16'h0300;
    step();
    b0.i_wren = 0;
    check("empty_both_count", b0.o_count, 1);
    check("empty_both_underflow", b0.o_underflow, 1);
    check("empty_both_valid", b0.o_valid, 0);
    step();
    check("empty_both_data", b0.o_rddata, 16'h0300);
    check("empty_both_drained", b0.o_count, 0);
    b0.i_clr_err = 1;
    step();
    check("clr_vs_event", b0.o_underflow, 1);
    b0.i_rden = 0;
    step();
    b0.i_clr_err = 0;
    check("clr_after", b0.o_underflow, 0);

    // Mid-operation reset
    for (int i = 0; i < 5; i++) begin
      b0.i_wren = 1; b0.i_wrdata = DW'(16'h0400 + i);
      step();
    end
    b0.i_wren = 0;
    check("pre_rst_count", b0.o_count, 5);
    rstn = 0;
    step();
    check("mid_rst_count", b0.o_count, 0);
    check("mid_rst_empty", b0.o_empty, 1);
    check("mid_rst_rddata", b0.o_rddata, 0);
    rstn = 1;
    step();

    // FWFT instance
    check("fwft_idle_valid", b1.o_valid, 0);
    b1.i_wren = 1; b1.i_wrdata = 16'h0055;
    step();
    check("fwft_first_valid", b1.o_valid, 1);
    check("fwft_first_data", b1.o_rddata, 16'h0055);
    b1.i_wrdata = 16'h0066;
    step();
    b1.i_wren = 0;
    check("fwft_head_hold", b1.o_rddata, 16'h0055);
    check("fwft_count2", b1.o_count, 2);
    b1.i_rden = 1;
    step();
    check("fwft_pop_data", b1.o_rddata, 16'h0066);
    check("fwft_pop_valid", b1.o_valid, 1);
    step();
    b1.i_rden = 0;
    check("fwft_last_valid", b1.o_valid, 0);
    check("fwft_last_empty", b1.o_empty, 1);
    check("fwft_no_underflow", b1.o_underflow, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, successor to the fixed 128-bit/10-deep sync FIFO. It adds configurable data width and depth with non-power-of-two pointer wrap, and a first-word-fall-through (FWFT) mode. It also provides a fill-level output, sticky overflow/underflow error flags and defined simultaneous read/write-at-boundary behaviour. It sits between producer and consumer stages in the datapath as the standard buffering element.

## Interface
- DATA_WIDTH, 128, data bits per entry (≥1)
- DEPTH, 10, number of entries (≥2, any integer, not restricted to powers of two)
- UPP_TH, 4, almost-full margin: o_alm_full when count ≥ DEPTH−UPP_TH (0 ≤ UPP_TH < DEPTH)
- LOW_TH, 2, almost-empty level: o_alm_empty when count ≤ LOW_TH (0 ≤ LOW_TH < DEPTH)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- i_wren  in  1  write request
- i_wrdata  in  DATA_WIDTH  write data
- i_rden  in  1  read request (FWFT: pop head)
- o_rddata  out  DATA_WIDTH  read data
- o_valid  out  1  o_rddata valid
- o_full, o_empty  out  1 each  count==DEPTH / count==0
- o_alm_full, o_alm_empty  out  1 each  threshold flags
- o_count  out  CW  current occupancy 0..DEPTH
- i_clr_err  in  1  clears sticky error flags
- o_overflow, o_underflow  out  1 each  sticky error flags

## Operation
- Reset (rstn=0 at clk edge): count=0, read and write pointers=0, o_rddata=0, o_valid=0, o_overflow=0, o_underflow=0.
- Post-reset flag values: o_empty=1, o_full=0, o_alm_empty=1, o_alm_full=0. Memory contents are not reset.
- Read accepted (rd_ok) = i_rden && count>0.
- Write accepted (wr_ok) = i_wren && (count<DEPTH || rd_ok).
- At full with both requests: both are accepted, count is unchanged.
- At empty with both requests: write only is accepted, and underflow is set.
- count_next = count + wr_ok − rd_ok. It never exceeds DEPTH and never goes below 0.
- Pointers increment on acceptance. Each wraps from DEPTH−1 to 0 (explicit compare, not bit truncation).
- All five status outputs (o_full, o_empty, o_alm_full, o_alm_empty, o_count) decode combinationally from the registered count.
- o_overflow sets when i_wren && !wr_ok. o_underflow sets when i_rden && !rd_ok.
- Both error flags hold until i_clr_err=1. If an error event and i_clr_err occur in the same cycle, the flag is set (the event wins).
- Rejected requests do not modify pointers, count, memory or o_rddata.
- FWFT=0:
  - On rd_ok, o_rddata ← mem[rd_ptr] at the clock edge and o_valid=1 for that one following cycle.
  - Otherwise o_valid=0 and o_rddata holds its last value.
- FWFT=1:
  - o_rddata = mem[rd_ptr] whenever count>0; o_valid = !o_empty.
  - i_rden acknowledges the current head; the next entry appears the cycle after rd_ok.
  - A write into an empty FIFO is visible on o_rddata the cycle after the write edge.
- Reset mid-operation discards all contents and returns all outputs to their reset values at the next edge.

## Timing
- Write-to-count latency: 1 cycle. Flags update in the same cycle as o_count.
- FWFT=0 read latency: 1 cycle from the rd_ok edge to valid data.
- FWFT=0 back-to-back reads give one word per cycle with o_valid held high.
- FWFT=1 read latency: 0 cycles (head already presented). Write-to-first-visible latency: 1 cycle.
- Sustained throughput: one write and one read per cycle in any occupancy state, including full.
- Error flags assert 1 cycle after the offending request.

## Test plan
- **Reset check.** Hold rstn=0 for 2 cycles with DEPTH=10. Required: o_empty=1, o_alm_empty=1, o_count=0, o_full=0, o_valid=0, o_overflow=0.
- **Fill and drain (FWFT=0).** Write 10 words 0x1..0xA.
  - After word 6, o_alm_full=1; after word 10, o_full=1 and o_count=10.
  - An 11th write sets o_overflow, and o_count stays 10.
  - Draining 10 reads returns 0x1..0xA, each 1 cycle after its read; o_alm_empty=1 at count≤2.
- **Wrap-around with DEPTH=10.** Run 25 interleaved writes/reads with a random gap pattern. Required: the output sequence equals the input sequence and pointers wrap 9→0 with no data loss.
- **Simultaneous access at boundaries.**
  - At full, i_wren=i_rden=1 for 3 cycles: o_count stays 10, no overflow, order is preserved.
  - At empty, i_wren=i_rden=1: o_count=1 and o_underflow=1.
- **FWFT=1.**
  - Write 0x55 into empty: next cycle o_valid=1, o_rddata=0x55.
  - Write 0x66, then pop: o_rddata=0x66 the following cycle.
  - Pop again: o_valid=0.
- **Error clear and mid-operation reset.**
  - Assert i_clr_err with no event: flags return to 0. Assert i_clr_err together with a new underflow: o_underflow stays 1.
  - Drop rstn with 5 entries stored: next cycle o_count=0 and o_empty=1.
